// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and writeback entry type for the register file write path
package regfile_pkg;

   localparam int RF_DATA_W = 8;
   localparam int RF_ADDR_W = 3;

   // one queued register writeback
   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_bypass_lookup.sv
// rtl/regfile_bypass_lookup.sv - youngest-match search over age-ordered pending writebacks
module regfile_bypass_lookup
   import regfile_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [RF_ADDR_W-1:0] i_addr,
   input  logic [N-1:0]         i_valid,
   input  wb_entry_t [N-1:0]    i_entries,
   output logic                 o_hit,
   output logic [RF_DATA_W-1:0] o_data
);

   // slot 0 is the youngest; scan oldest to youngest so the youngest match is written last
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_valid[i] && (i_entries[i].rd == i_addr)) begin
            o_hit  = 1'b1;
            o_data = i_entries[i].data;
         end
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - writeback queue draining onto the register file write port, with bypass
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_rd,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_rd,
   output logic [DATA_W-1:0]        rf_data,
   input  logic [ADDR_W-1:0]        lk1_addr,
   output logic                     lk1_hit,
   output logic [DATA_W-1:0]        lk1_data,
   input  logic [ADDR_W-1:0]        lk2_addr,
   output logic                     lk2_hit,
   output logic [DATA_W-1:0]        lk2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic               r_we;
   logic [ADDR_W-1:0]  r_rd;
   logic [DATA_W-1:0]  r_data;

   logic               w_push;
   logic               w_pop;
   wb_entry_t          w_head_entry;

   // full refuses pushes even when a pop happens in the same cycle
   assign in_ready     = rst_n && (r_count < CNT_W'(DEPTH));
   assign w_push       = in_valid && in_ready;
   assign w_pop        = (r_count != '0);
   assign w_head_entry = r_mem[r_head];

   // storage writes need no reset; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= '{rd: in_rd, data: in_data};
      end
   end

   // pointer/count bookkeeping and the registered write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_we   <= 1'b1;
            r_rd   <= w_head_entry.rd;
            r_data <= w_head_entry.data;
            r_head <= r_head + 1'b1;
         end else begin
            r_we   <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rf_we   = r_we;
   assign rf_rd   = r_rd;
   assign rf_data = r_data;
   assign count   = r_count;
   assign idle    = (r_count == '0) && !r_we;

   // age-ordered view for the bypass: slot 0 = tail-1 (youngest), slot DEPTH = output stage
   wb_entry_t [DEPTH:0] w_lk_entries;
   logic      [DEPTH:0] w_lk_valid;

   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign w_lk_entries[k] = r_mem[r_tail - PTR_W'(k + 1)];
      assign w_lk_valid[k]   = (CNT_W'(k) < r_count);
   end

   assign w_lk_entries[DEPTH] = '{rd: r_rd, data: r_data};
   assign w_lk_valid[DEPTH]   = r_we;

   regfile_bypass_lookup #(.N(DEPTH + 1)) u_lk1 (
      .i_addr    (lk1_addr),
      .i_valid   (w_lk_valid),
      .i_entries (w_lk_entries),
      .o_hit     (lk1_hit),
      .o_data    (lk1_data)
   );

   regfile_bypass_lookup #(.N(DEPTH + 1)) u_lk2 (
      .i_addr    (lk2_addr),
      .i_valid   (w_lk_valid),
      .i_entries (w_lk_entries),
      .o_hit     (lk2_hit),
      .o_data    (lk2_data)
   );

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - self-checking bench with a queue-based reference model
module tb_regfile_write_queue;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_rd;
   logic [7:0] in_data;
   logic       rf_we;
   logic [2:0] rf_rd;
   logic [7:0] rf_data;
   logic [2:0] lk1_addr;
   logic       lk1_hit;
   logic [7:0] lk1_data;
   logic [2:0] lk2_addr;
   logic       lk2_hit;
   logic [7:0] lk2_data;
   logic [2:0] count;
   logic       idle;

   always #5 clk = ~clk;

   regfile_write_queue #(.DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rd    (in_rd),
      .in_data  (in_data),
      .rf_we    (rf_we),
      .rf_rd    (rf_rd),
      .rf_data  (rf_data),
      .lk1_addr (lk1_addr),
      .lk1_hit  (lk1_hit),
      .lk1_data (lk1_data),
      .lk2_addr (lk2_addr),
      .lk2_hit  (lk2_hit),
      .lk2_data (lk2_data),
      .count    (count),
      .idle     (idle)
   );

   typedef struct {
      logic [2:0] rd;
      logic [7:0] data;
   } ent_t;

   // reference model: pending entries oldest-first, plus the output stage
   ent_t       mq[$];
   logic       m_we;
   logic [2:0] m_rd;
   logic [7:0] m_data;
   logic       known = 1'b0;
   logic [7:0] rf_arr [8];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void mlook(input logic [2:0] a, output logic h, output logic [7:0] d);
      h = 1'b0;
      d = 8'h00;
      if (m_we && m_rd == a) begin
         h = 1'b1;
         d = m_data;
      end
      foreach (mq[i]) begin
         if (mq[i].rd == a) begin
            h = 1'b1;
            d = mq[i].data;
         end
      end
   endfunction

   task automatic compare_all();
      logic       h;
      logic [7:0] d;
      chk("in_ready", in_ready, (rst_n && mq.size() < DEPTH));
      chk("count", count, mq.size());
      chk("idle", idle, (mq.size() == 0 && !m_we));
      chk("rf_we", rf_we, m_we);
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_data", rf_data, m_data);
      mlook(lk1_addr, h, d);
      chk("lk1_hit", lk1_hit, h);
      chk("lk1_data", lk1_data, d);
      mlook(lk2_addr, h, d);
      chk("lk2_hit", lk2_hit, h);
      chk("lk2_data", lk2_data, d);
   endtask

   task automatic drive(input logic rst, input logic v, input logic [2:0] rd, input logic [7:0] d,
                        input logic [2:0] a1, input logic [2:0] a2);
      rst_n    = rst;
      in_valid = v;
      in_rd    = rd;
      in_data  = d;
      lk1_addr = a1;
      lk2_addr = a2;
      #1;
      if (known) compare_all();
   endtask

   task automatic advance();
      logic push;
      ent_t e;
      ent_t p;
      push   = rst_n && in_valid && (mq.size() < DEPTH);
      p.rd   = in_rd;
      p.data = in_data;
      if (known && rf_we) rf_arr[rf_rd] = rf_data;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_we   = 1'b0;
         m_rd   = 3'd0;
         m_data = 8'h00;
      end else begin
         if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_rd   = e.rd;
            m_data = e.data;
         end else begin
            m_we = 1'b0;
         end
         if (push) mq.push_back(p);
      end
      known = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; lk1_addr = '0; lk2_addr = '0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
      foreach (rf_arr[i]) rf_arr[i] = 8'h00;
      @(negedge clk);

      // reset with a request present
      drive(1'b0, 1'b1, 3'd1, 8'h12, 3'd0, 3'd0); advance();
      drive(1'b0, 1'b1, 3'd1, 8'h12, 3'd0, 3'd0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_count", count, 0);
      chk("rst_idle", idle, 1);
      advance();

      // single write: push at edge N, rf_we visible only in cycle N+1
      drive(1'b1, 1'b1, 3'd1, 8'hAA, 3'd0, 3'd0); advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("single_count_n", count, 1);
      chk("single_we_n", rf_we, 0);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("single_we", rf_we, 1);
      chk("single_rd", rf_rd, 1);
      chk("single_data", rf_data, 8'hAA);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("single_we_off", rf_we, 0);
      chk("single_idle", idle, 1);
      advance();

      // burst r1..r5 back to back, drained in order on consecutive cycles
      for (int i = 1; i <= 7; i++) begin
         if (i <= 5) drive(1'b1, 1'b1, 3'(i), 8'(i * 8'h11), 3'd0, 3'd0);
         else        drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
         if (i >= 3) begin
            chk("burst_we", rf_we, 1);
            chk("burst_rd", rf_rd, i - 2);
            chk("burst_data", rf_data, (i - 2) * 8'h11);
         end
         advance();
      end
      repeat (2) begin drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); advance(); end

      // bypass youngest: r3=F0 then r3=0F
      drive(1'b1, 1'b1, 3'd3, 8'hF0, 3'd3, 3'd6); advance();
      drive(1'b1, 1'b1, 3'd3, 8'h0F, 3'd3, 3'd6);
      chk("byp_first_hit", lk1_hit, 1);
      chk("byp_first_data", lk1_data, 8'hF0);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6);
      chk("byp_young_hit", lk1_hit, 1);
      chk("byp_young_data", lk1_data, 8'h0F);
      chk("byp_miss_hit", lk2_hit, 0);
      chk("byp_miss_data", lk2_data, 8'h00);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6);
      chk("byp_out_data", lk1_data, 8'h0F);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd6);
      chk("byp_gone", lk1_hit, 0);
      advance();

      // output-stage bypass
      drive(1'b1, 1'b1, 3'd2, 8'hCC, 3'd2, 3'd0); advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd0); advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd0);
      chk("ostage_count", count, 0);
      chk("ostage_hit", lk1_hit, 1);
      chk("ostage_data", lk1_data, 8'hCC);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd0);
      chk("ostage_gone", lk1_hit, 0);
      advance();

      // overwrite lands oldest first, so the final value is the younger one
      drive(1'b1, 1'b1, 3'd1, 8'hAA, 3'd0, 3'd0); advance();
      drive(1'b1, 1'b1, 3'd1, 8'h0F, 3'd0, 3'd0); advance();
      repeat (4) begin drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); advance(); end
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("ovw_idle", idle, 1);
      chk("ovw_r1", rf_arr[1], 8'h0F);
      advance();

      // reset mid-operation discards everything
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 3'(i + 4), 8'(8'h40 + i), 3'd0, 3'd0); advance();
      end
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("mrst_we", rf_we, 0);
      chk("mrst_count", count, 0);
      advance();
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      chk("mrst_we2", rf_we, 0);
      chk("mrst_idle", idle, 1);
      advance();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
               3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end of the 8x8 register file: buffers register writebacks (rd, data) from the execute stage and drains them one per cycle onto the register file write port (we/rd/data).
- Provides two bypass lookup ports, so operand reads see the youngest value still queued or in flight.
- Sits between the execute/load result path and register_file.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register index width (2^ADDR_W registers)
- DEPTH, 4, queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  writeback request present
- in_ready  out  1  queue can accept this cycle
- in_rd  in  ADDR_W  destination register index
- in_data  in  DATA_W  writeback value
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  ADDR_W  register file write index (registered)
- rf_data  out  DATA_W  register file write data (registered)
- lk1_addr  in  ADDR_W  bypass lookup 1 index (tie to rs1)
- lk1_hit  out  1  lookup 1 matches a pending write
- lk1_data  out  DATA_W  youngest pending value for lk1_addr
- lk2_addr  in  ADDR_W  bypass lookup 2 index (tie to rs2)
- lk2_hit  out  1
- lk2_data  out  DATA_W
- count  out  ADDR_W+1 .. clog2(DEPTH)+1  queue occupancy, excludes output stage
- idle  out  1  count==0 and rf_we==0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at an edge): head=tail=count=0, rf_we=0, rf_rd=0, rf_data=0. in_ready is driven 0 while rst_n=0. Reset mid-operation discards all queued entries and any in-flight write; no rf_we pulse follows.
- Storage: circular buffer, DEPTH entries, head/tail pointers wrapping mod DEPTH.
- Accept: push when in_valid && in_ready. in_ready = rst_n && (count < DEPTH), combinational, independent of in_valid.
- Full: no push, even if a pop occurs the same cycle (no pass-through when full).
- Drain, every edge:
  - if count>0: rf_we<=1, rf_rd/rf_data<=head entry, head++.
  - else: rf_we<=0, rf_rd/rf_data hold.
- Throughput: one write per cycle.
- Latency: an entry pushed at edge N into an empty queue drives rf_we in cycle N+1 (between edges N+1 and N+2) and lands in the register file at edge N+2.
- Simultaneous push+pop: count unchanged; the pushed entry is never the popped one (push completes first).
- Ordering: strict FIFO. Duplicate rd entries are all written, oldest first.
- Bypass (combinational):
  - Search valid queue entries and the output stage (rf_we=1) for a match on lk*_addr.
  - hit=1 if any match. data = youngest match: queue entries tail-1 back to head, then the output stage.
  - No match: hit=0, data=0.
  - The current-cycle in_* request is not searched.
- Register 0 is ordinary: no special casing.
- count is exact. idle=1 only when nothing is queued or in flight.

Decomposition:
- Package regfile_pkg: DATA_W/ADDR_W constants and a wb_entry_t struct {rd, data}.
- Sub-module regfile_bypass_lookup: a youngest-match priority search over DEPTH+1 entries, instantiated twice.
- FIFO storage and output register stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, rf_we=0, count=0, idle=1. Pulse rst_n=0 after 3 pushes -> no rf_we after reset, count=0.
- Single write: push r1=0xAA at edge N -> rf_we=1, rf_rd=1, rf_data=0xAA in cycle N+1 only. idle returns to 1 at N+2.
- Burst/full: hold the drain model with 5 back-to-back pushes r1..r5 (0x11..0x55) -> rf_we pulses r1..r5 in order on consecutive cycles. A push while count==DEPTH is refused (in_ready=0).
- Bypass youngest: push r3=0xF0 then r3=0x0F; lk1_addr=3 -> hit=1, data=0x0F while either entry is pending. lk2_addr=6 -> hit=0, data=0.
- Output-stage bypass: single push r2=0xCC; in the cycle rf_we=1 with queue empty, lk1_addr=2 -> hit=1, data=0xCC; next cycle hit=0.
- Overwrite end-to-end with register_file: write r1=0xAA, then r1=0x0F -> after idle, register_file rs1_out for r1 = 0x0F.
